// File: rtl/nco_sweep_controller_if.sv
// Configuration handshake bundle for nco_sweep_controller.
// The cfg_loop field exists only when NCO_SWEEP_LOOP_EN is defined.
interface nco_sweep_controller_if #(
    parameter int PHASE_WIDTH = 64,
    parameter int DIV_WIDTH   = 16,
    parameter int DWELL_WIDTH = 16,
    parameter int STEPS_WIDTH = 16
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [PHASE_WIDTH-1:0] cfg_start_inc;
    logic [PHASE_WIDTH-1:0] cfg_step_inc;
    logic [STEPS_WIDTH-1:0] cfg_num_steps;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic [DIV_WIDTH-1:0]   cfg_ce_div;
`ifdef NCO_SWEEP_LOOP_EN
    logic                   cfg_loop;

    modport master (
        output cfg_valid, cfg_start_inc, cfg_step_inc,
        output cfg_num_steps, cfg_dwell, cfg_ce_div, cfg_loop,
        input  cfg_ready
    );
    modport slave (
        input  cfg_valid, cfg_start_inc, cfg_step_inc,
        input  cfg_num_steps, cfg_dwell, cfg_ce_div, cfg_loop,
        output cfg_ready
    );
`else
    modport master (
        output cfg_valid, cfg_start_inc, cfg_step_inc,
        output cfg_num_steps, cfg_dwell, cfg_ce_div,
        input  cfg_ready
    );
    modport slave (
        input  cfg_valid, cfg_start_inc, cfg_step_inc,
        input  cfg_num_steps, cfg_dwell, cfg_ce_div,
        output cfg_ready
    );
`endif
endinterface

// File: rtl/nco_sweep_controller.sv
// NCO sample-enable divider and linear phase-increment sweep sequencer.
// Optional NCO_SWEEP_LOOP_EN: latched cfg_loop repeats the sweep until abort.
module nco_sweep_controller #(
    parameter int PHASE_WIDTH = 64,
    parameter int DIV_WIDTH   = 16,
    parameter int DWELL_WIDTH = 16,
    parameter int STEPS_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   arst,
    nco_sweep_controller_if.slave  cfg,
    input  logic                   abort,
    output logic                   sample_clk_ce,
    output logic [PHASE_WIDTH-1:0] phase_increment,
    output logic                   busy,
    output logic                   done,
    output logic [STEPS_WIDTH-1:0] step_index
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

    state_e                 state_q;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic                   ce_q;
    logic [PHASE_WIDTH-1:0] inc_q;
    logic [PHASE_WIDTH-1:0] step_q;
    logic [STEPS_WIDTH-1:0] idx_q;
    logic [STEPS_WIDTH-1:0] nsteps_q;
    logic [DWELL_WIDTH-1:0] dwc_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic                   done_q;
    logic                   accept;
`ifdef NCO_SWEEP_LOOP_EN
    logic [PHASE_WIDTH-1:0] start_q;
    logic                   loop_q;
`endif

    assign cfg.cfg_ready   = (state_q == IDLE);
    assign accept          = cfg.cfg_valid & cfg.cfg_ready;
    assign busy            = (state_q == RUN);
    assign done            = done_q;
    assign sample_clk_ce   = ce_q;
    assign phase_increment = inc_q;
    assign step_index      = idx_q;

    always_comb begin
        div_d = accept ? cfg.cfg_ce_div : div_q;
        if (accept || (cnt_q == div_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    // ce is registered from the next count so it lines up with cnt_q==div_q
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            ce_q  <= (cnt_d == div_d);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            inc_q    <= '0;
            step_q   <= '0;
            idx_q    <= '0;
            nsteps_q <= '0;
            dwc_q    <= '0;
            dwell_q  <= '0;
            done_q   <= 1'b0;
`ifdef NCO_SWEEP_LOOP_EN
            start_q  <= '0;
            loop_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        inc_q    <= cfg.cfg_start_inc;
                        step_q   <= cfg.cfg_step_inc;
                        nsteps_q <= cfg.cfg_num_steps;
                        dwell_q  <= cfg.cfg_dwell;
                        idx_q    <= '0;
                        dwc_q    <= '0;
`ifdef NCO_SWEEP_LOOP_EN
                        start_q  <= cfg.cfg_start_inc;
                        loop_q   <= cfg.cfg_loop;
`endif
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (ce_q) begin
                        if (dwc_q < dwell_q) begin
                            dwc_q <= dwc_q + DWELL_WIDTH'(1);
                        end else if (idx_q < nsteps_q) begin
                            inc_q <= inc_q + step_q;
                            idx_q <= idx_q + STEPS_WIDTH'(1);
                            dwc_q <= '0;
                        end else begin
                            done_q <= 1'b1;
`ifdef NCO_SWEEP_LOOP_EN
                            if (loop_q) begin
                                inc_q <= start_q;
                                idx_q <= '0;
                                dwc_q <= '0;
                            end else begin
                                state_q <= FINISH;
                            end
`else
                            state_q <= FINISH;
`endif
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nco_sweep_controller.sv
// Directed bench for nco_sweep_controller.
// Loop scenario runs only when NCO_SWEEP_LOOP_EN is defined.
module tb_nco_sweep_controller;
    logic        clk;
    logic        arst;
    logic        abort;
    logic        sample_clk_ce;
    logic [63:0] phase_increment;
    logic        busy;
    logic        done;
    logic [15:0] step_index;
    int          checks;
    int          errors;

    nco_sweep_controller_if #(
        .PHASE_WIDTH(64),
        .DIV_WIDTH  (16),
        .DWELL_WIDTH(16),
        .STEPS_WIDTH(16)
    ) cif ();

    nco_sweep_controller #(
        .PHASE_WIDTH(64),
        .DIV_WIDTH  (16),
        .DWELL_WIDTH(16),
        .STEPS_WIDTH(16)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .cfg            (cif),
        .abort          (abort),
        .sample_clk_ce  (sample_clk_ce),
        .phase_increment(phase_increment),
        .busy           (busy),
        .done           (done),
        .step_index     (step_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [63:0] s, input logic [63:0] st,
                         input logic [15:0] n, input logic [15:0] d,
                         input logic [15:0] cd);
        cif.cfg_start_inc = s;
        cif.cfg_step_inc  = st;
        cif.cfg_num_steps = n;
        cif.cfg_dwell     = d;
        cif.cfg_ce_div    = cd;
        cif.cfg_valid     = 1'b1;
        tick();
        cif.cfg_valid     = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        abort = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_start_inc = '0;
        cif.cfg_step_inc = '0;
        cif.cfg_num_steps = '0;
        cif.cfg_dwell = '0;
        cif.cfg_ce_div = '0;
`ifdef NCO_SWEEP_LOOP_EN
        cif.cfg_loop = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sample_clk_ce !== 1'b0) begin
            errors++;
            $display("FAIL rst_ce: got %b want 0", sample_clk_ce);
        end
        checks++;
        if (phase_increment !== 64'h0) begin
            errors++;
            $display("FAIL rst_phase: got %h want 0", phase_increment);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_done: got %b%b want 00", busy, done);
        end
        checks++;
        if (step_index !== 16'h0) begin
            errors++;
            $display("FAIL rst_step: got %h want 0", step_index);
        end
        arst = 1'b0;
        #1;
        checks++;
        if (cif.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: got %b want 1", cif.cfg_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sample_clk_ce !== 1'b1) begin
                errors++;
                $display("FAIL rst_ce_div0 cyc%0d: got %b want 1", i, sample_clk_ce);
            end
        end
    endtask

    task automatic test_sweep();
        int          ces;
        int          last;
        bit          fin;
        logic [63:0] exp;
        offer(64'h1000, 64'h100, 16'd3, 16'd1, 16'd3);
        checks++;
        if (busy !== 1'b1 || cif.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL sweep_start: busy %b ready %b want 1 0", busy, cif.cfg_ready);
        end
        checks++;
        if (phase_increment !== 64'h1000 || step_index !== 16'd0) begin
            errors++;
            $display("FAIL sweep_first: got %h/%0d want 1000/0", phase_increment, step_index);
        end
        ces = 0;
        last = 0;
        fin = 0;
        for (int c = 1; c <= 64 && !fin; c++) begin
            if (c > 1) tick();
            if (sample_clk_ce) begin
                ces++;
                exp = 64'h1000 + 64'h100 * 64'((ces - 1) / 2);
                checks++;
                if (c - last !== 4) begin
                    errors++;
                    $display("FAIL sweep_gap ce%0d: got %0d want 4", ces, c - last);
                end
                checks++;
                if (phase_increment !== exp) begin
                    errors++;
                    $display("FAIL sweep_phase ce%0d: got %h want %h", ces, phase_increment, exp);
                end
                checks++;
                if (step_index !== 16'((ces - 1) / 2)) begin
                    errors++;
                    $display("FAIL sweep_step ce%0d: got %0d want %0d", ces, step_index, (ces - 1) / 2);
                end
                last = c;
            end
            if (done) begin
                fin = 1;
                checks++;
                if (ces !== 8) begin
                    errors++;
                    $display("FAIL sweep_len: got %0d ces want 8", ces);
                end
                checks++;
                if (c !== last + 1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_done_at: cyc %0d busy %b want %0d 0", c, busy, last + 1);
                end
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL sweep_timeout: got no done want done");
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cif.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_idle: done %b busy %b ready %b want 0 0 1", done, busy, cif.cfg_ready);
        end
        checks++;
        if (phase_increment !== 64'h1300 || step_index !== 16'd3) begin
            errors++;
            $display("FAIL sweep_hold: got %h/%0d want 1300/3", phase_increment, step_index);
        end
    endtask

    task automatic test_wrap();
        offer(64'h400, 64'hFFFF_FFFF_FFFF_F800, 16'd1, 16'd0, 16'd0);
        checks++;
        if (sample_clk_ce !== 1'b1 || phase_increment !== 64'h400) begin
            errors++;
            $display("FAIL wrap_t0: ce %b got %h want 1 400", sample_clk_ce, phase_increment);
        end
        tick();
        checks++;
        if (phase_increment !== 64'hFFFF_FFFF_FFFF_FC00 || step_index !== 16'd1) begin
            errors++;
            $display("FAIL wrap_t1: got %h/%0d want fffffffffffffc00/1", phase_increment, step_index);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: done %b busy %b want 1 0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || phase_increment !== 64'hFFFF_FFFF_FFFF_FC00) begin
            errors++;
            $display("FAIL wrap_hold: done %b got %h want 0 fffffffffffffc00", done, phase_increment);
        end
    endtask

    task automatic test_abort();
        int ces;
        offer(64'h10, 64'h1, 16'd16, 16'd1, 16'd1);
        ces = 0;
        for (int c = 1; c <= 40 && ces < 5; c++) begin
            if (c > 1) tick();
            if (sample_clk_ce) ces++;
        end
        checks++;
        if (ces !== 5) begin
            errors++;
            $display("FAIL abort_timeout: got %0d ces want 5", ces);
        end
        tick();
        checks++;
        if (phase_increment !== 64'h12 || step_index !== 16'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got %h/%0d busy %b want 12/2 1", phase_increment, step_index, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cif.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: busy %b ready %b want 0 1", busy, cif.cfg_ready);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (done !== 1'b0 || phase_increment !== 64'h12 || step_index !== 16'd2) begin
                errors++;
                $display("FAIL abort_frozen cyc%0d: done %b got %h/%0d want 0 12/2", i, done, phase_increment, step_index);
            end
            tick();
        end
    endtask

    task automatic test_busy_cfg();
        int ces;
        int last;
        bit fin;
        offer(64'h2000, 64'h10, 16'd2, 16'd0, 16'd0);
        cif.cfg_start_inc = 64'hDEAD;
        cif.cfg_step_inc  = 64'h1;
        cif.cfg_num_steps = 16'd7;
        cif.cfg_dwell     = 16'd4;
        cif.cfg_ce_div    = 16'd5;
        cif.cfg_valid     = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            checks++;
            if (phase_increment !== 64'h2000 + 64'h10 * 64'(c - 1) || sample_clk_ce !== 1'b1) begin
                errors++;
                $display("FAIL busy_cfg_t%0d: got %h ce %b want %h 1", c, phase_increment, sample_clk_ce, 64'h2000 + 64'h10 * 64'(c - 1));
            end
            checks++;
            if (cif.cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_cfg_ready%0d: got %b want 0", c, cif.cfg_ready);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL busy_cfg_done: got %b want 1", done);
        end
        cif.cfg_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || phase_increment !== 64'h2020 || step_index !== 16'd2) begin
            errors++;
            $display("FAIL busy_cfg_end: busy %b got %h/%0d want 0 2020/2", busy, phase_increment, step_index);
        end
        abort = 1'b1;
        offer(64'h5555, 64'h1, 16'd1, 16'd0, 16'd2);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || phase_increment !== 64'h5555 || step_index !== 16'd0) begin
            errors++;
            $display("FAIL abort_cfg_accept: busy %b got %h/%0d want 1 5555/0", busy, phase_increment, step_index);
        end
        ces = 0;
        last = 0;
        fin = 0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            if (c > 1) tick();
            if (sample_clk_ce) begin
                ces++;
                last = c;
            end
            if (done) begin
                fin = 1;
                checks++;
                if (ces !== 2 || c !== 7) begin
                    errors++;
                    $display("FAIL abort_cfg_len: got %0d ces at cyc %0d want 2 at 7", ces, c);
                end
            end
        end
        checks++;
        if (!fin || phase_increment !== 64'h5556) begin
            errors++;
            $display("FAIL abort_cfg_end: fin %b got %h want 1 5556", fin, phase_increment);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        offer(64'hABC, 64'h1, 16'd5, 16'd3, 16'd0);
        tick();
        checks++;
        if (busy !== 1'b1 || phase_increment !== 64'hABC) begin
            errors++;
            $display("FAIL rmid_pre: busy %b got %h want 1 abc", busy, phase_increment);
        end
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if (phase_increment !== 64'h0 || busy !== 1'b0 || step_index !== 16'd0 || sample_clk_ce !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: got %h busy %b step %0d ce %b want 0 0 0 0", phase_increment, busy, step_index, sample_clk_ce);
        end
        @(negedge clk);
        arst = 1'b0;
        #1;
        checks++;
        if (cif.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_ready: got %b want 1", cif.cfg_ready);
        end
        @(negedge clk);
    endtask

`ifdef NCO_SWEEP_LOOP_EN
    task automatic test_loop();
        logic [63:0] exp;
        logic        exp_d;
        cif.cfg_loop = 1'b1;
        offer(64'h100, 64'h100, 16'd2, 16'd0, 16'd0);
        cif.cfg_loop = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) tick();
            exp = 64'h100 * 64'((c - 1) % 3 + 1);
            exp_d = (c > 1) && ((c - 1) % 3 == 0);
            checks++;
            if (phase_increment !== exp || done !== exp_d || busy !== 1'b1) begin
                errors++;
                $display("FAIL loop_t%0d: got %h done %b busy %b want %h %b 1", c, phase_increment, done, busy, exp, exp_d);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cif.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL loop_abort: busy %b done %b ready %b want 0 0 1", busy, done, cif.cfg_ready);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sweep();
        test_wrap();
        test_abort();
        test_busy_cfg();
`ifdef NCO_SWEEP_LOOP_EN
        test_loop();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nco_sweep_controller.md
Name: nco_sweep_controller

Overview:
Sequencer for the team's phase-accumulator sine/cosine NCO. It generates the NCO's sample clock enable with a programmable divider and drives the NCO's phase increment through a linear frequency sweep (start increment, signed step, step count, dwell per step). Configuration is accepted through a valid/ready handshake from the host/control plane. The block reports busy/done status and supports abort.

Parameters:
PHASE_WIDTH, 64, width of phase_increment and of the increment config fields
DIV_WIDTH, 16, width of the sample-enable divider value
DWELL_WIDTH, 16, width of the dwell count (sample enables per step, minus 1)
STEPS_WIDTH, 16, width of the step count and step index

Ports:
clk  input  1  system clock
arst  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  high when a configuration can be accepted (IDLE only)
cfg_start_inc  input  PHASE_WIDTH  first phase increment of the sweep
cfg_step_inc  input  PHASE_WIDTH  signed increment added per step
cfg_num_steps  input  STEPS_WIDTH  number of steps after the first tone; 0 means a single tone
cfg_dwell  input  DWELL_WIDTH  each tone is held for cfg_dwell+1 sample enables
cfg_ce_div  input  DIV_WIDTH  sample_clk_ce is asserted once every cfg_ce_div+1 clocks
abort  input  1  terminate the running sweep
sample_clk_ce  output  1  one-clk sample enable to the NCO
phase_increment  output  PHASE_WIDTH  signed increment to the NCO
busy  output  1  sweep in progress
done  output  1  one-clk pulse at normal sweep completion
step_index  output  STEPS_WIDTH  index of the tone currently output

Behaviour:
- Reset (arst high, asynchronous): state IDLE; phase_increment=0, step_index=0, busy=0, done=0, sample_clk_ce=0; divider count=0; latched divider=0; dwell count=0. cfg_ready=1 once reset is released.
- Divider: free-running in all states. Count runs 0..div_latched. sample_clk_ce=1 for the clk where count==div_latched, then count returns to 0. div_latched=0 means sample_clk_ce is high every clk. div_latched loads cfg_ce_div on accept, and the count clears to 0 on accept.
- States: IDLE, RUN, FINISH. cfg_ready = (state==IDLE), combinational from state. busy = (state==RUN).
- Accept: cfg_valid&cfg_ready at a clk edge. Latch all cfg_* fields. phase_increment<=cfg_start_inc and step_index<=0 on that edge. Dwell count<=0. Go to RUN.
- RUN: on each sample_clk_ce where dwell count<dwell, increment the dwell count.
  - On a sample_clk_ce where dwell count==dwell and step_index<num_steps: phase_increment<=phase_increment+step_inc (two's complement, wraps modulo 2^PHASE_WIDTH, no saturation); step_index++; dwell count<=0.
  - On a sample_clk_ce where dwell count==dwell and step_index==num_steps: go to FINISH.
- Timing: every register update is aligned to the clk edge ending the CE cycle. The NCO therefore uses the new increment from the next sample enable. Tone k is presented for exactly (dwell+1) enables.
- FINISH: done=1 for exactly one clk, then go to IDLE. phase_increment and step_index hold their final values, so the last tone persists.
- Total sweep length: (num_steps+1)*(dwell+1) sample enables from accept to the FINISH entry.
- abort in RUN: on the next edge go to IDLE. done is not asserted. phase_increment and step_index hold their current values.
- abort in IDLE or FINISH: ignored. abort together with cfg_valid in IDLE: the configuration is accepted.
- cfg_valid while busy: not accepted. cfg_ready=0, and the fields are not sampled.
- arst mid-sweep: immediate return to the reset values above. The NCO sees phase_increment=0.

Optional Feature:
Macro NCO_SWEEP_LOOP_EN. When defined:
- Adds input port cfg_loop (1 bit), latched on accept.
- If latched cfg_loop=1, the end-of-sweep CE pulses done for one clk, reloads phase_increment<=start_inc, step_index<=0 and dwell count<=0, and stays in RUN.
- The sweep repeats until abort. busy stays 1 throughout.
When undefined: no cfg_loop port; every sweep is single-shot via FINISH.

Test Plan:
1. Reset → phase_increment=0, busy=0, done=0, cfg_ready=1, and with cfg_ce_div=0 sample_clk_ce is high every clk after release.
2. cfg_ce_div=3, start=0x1000, step=0x100, num_steps=3, dwell=1 → CE every 4 clks; increments 0x1000,0x1100,0x1200,0x1300, each held 2 CEs; done pulses once after 8 CEs; final value 0x1300 held in IDLE.
3. step=-0x800 (two's complement), start=0x400, num_steps=1, dwell=0 → second tone 0xFFFF_FFFF_FFFF_FC00; wrap verified.
4. abort asserted after 5 CEs of a 16-step sweep → busy drops next clk, no done, phase_increment and step_index frozen, cfg_ready=1.
5. cfg_valid held while busy with different fields → ignored, sweep unaffected; abort together with cfg_valid in IDLE → config accepted.
6. With NCO_SWEEP_LOOP_EN, cfg_loop=1, num_steps=2, dwell=0 → done pulses every 3 CEs, increment sequence repeats, busy stays high until abort.
